// File: rtl/rr_grant_arbiter_pkg.sv
// Shared constants, state type and one-hot encode helper for the round-robin grant arbiter.
package arb_pkg;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Encode a one-hot (or all-zero) vector to its bit index; all-zero encodes to 0.
    function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = {ARB_IDX_W{1'b0}};
        for (int i = 0; i < ARB_N; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int IDX_W = ARB_IDX_W
) ();

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );

endinterface

// File: rtl/rr_grant_arbiter_prio_enc.sv
// Rotating first-set-bit search: returns the first requester at or after ptr, wrapping 7 to 0.
module rr_prio_enc
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_IDX_W-1:0] sel,
    output logic                 any_req
);

    logic [ARB_N-1:0]     rot_s;
    logic [ARB_N-1:0]     first_s;
    logic [ARB_IDX_W-1:0] src_s;

    // Rotate so rot_s[0] is requester ptr, isolate the lowest set bit, map back to an index
    always_comb begin
        rot_s = {ARB_N{1'b0}};
        src_s = {ARB_IDX_W{1'b0}};
        for (int i = 0; i < ARB_N; i++) begin
            src_s    = ptr + ARB_IDX_W'(i);
            rot_s[i] = req[src_s];
        end
        first_s = rot_s & (~rot_s + ARB_N'(1));
        sel     = ptr + onehot_to_idx(first_s);
        any_req = |req;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for an 8-way shared slot: registered one-hot grant plus index,
// held while the owner keeps requesting, preempted after MAX_HOLD cycles if others wait.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDX_W    = ARB_IDX_W,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_grant_arbiter_if.slave bus
);

    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_NONE  = IDX_W'(0);
    localparam logic [N-1:0]      GNT_ONE   = N'(1);
    localparam logic [N-1:0]      GNT_NONE  = N'(0);

    arb_state_e        state_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [N-1:0]      gnt_r;
    logic [IDX_W-1:0]  gnt_idx_r;
    logic              gnt_valid_r;
    logic              preempt_r;

    logic [IDX_W-1:0]  enc_ptr_s;
    logic [IDX_W-1:0]  enc_sel_s;
    logic              enc_any_s;
    logic              owner_req_s;
    logic              others_s;
    logic              limit_s;

    // One search serves both IDLE (from ptr) and handoff (from the slot after the owner)
    always_comb begin
        enc_ptr_s = ptr_r;
        if (state_r == OWNED) begin
            enc_ptr_s = gnt_idx_r + IDX_ONE;
        end else begin
            enc_ptr_s = ptr_r;
        end
    end

    rr_prio_enc u_prio_enc (
        .req     (bus.req),
        .ptr     (enc_ptr_s),
        .sel     (enc_sel_s),
        .any_req (enc_any_s)
    );

    assign owner_req_s = bus.req[gnt_idx_r];
    assign others_s    = |(bus.req & ~gnt_r);
    assign limit_s     = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LAST);

    // Grant state machine; every output is a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= IDX_NONE;
            hold_cnt_r  <= HOLD_ZERO;
            gnt_r       <= GNT_NONE;
            gnt_idx_r   <= IDX_NONE;
            gnt_valid_r <= 1'b0;
            preempt_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    preempt_r  <= 1'b0;
                    hold_cnt_r <= HOLD_ZERO;
                    if (enc_any_s) begin
                        state_r     <= OWNED;
                        gnt_r       <= GNT_ONE << enc_sel_s;
                        gnt_idx_r   <= enc_sel_s;
                        gnt_valid_r <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        gnt_r       <= GNT_NONE;
                        gnt_idx_r   <= IDX_NONE;
                        gnt_valid_r <= 1'b0;
                    end
                end
                OWNED: begin
                    if (!owner_req_s) begin
                        // Owner released: any other requester takes over with no idle bubble
                        ptr_r      <= gnt_idx_r + IDX_ONE;
                        preempt_r  <= 1'b0;
                        hold_cnt_r <= HOLD_ZERO;
                        if (enc_any_s) begin
                            state_r     <= OWNED;
                            gnt_r       <= GNT_ONE << enc_sel_s;
                            gnt_idx_r   <= enc_sel_s;
                            gnt_valid_r <= 1'b1;
                        end else begin
                            state_r     <= IDLE;
                            gnt_r       <= GNT_NONE;
                            gnt_idx_r   <= IDX_NONE;
                            gnt_valid_r <= 1'b0;
                        end
                    end else if (limit_s && others_s) begin
                        // Searching from owner+1 with another bit set can never land on the owner
                        state_r     <= OWNED;
                        ptr_r       <= gnt_idx_r + IDX_ONE;
                        preempt_r   <= 1'b1;
                        hold_cnt_r  <= HOLD_ZERO;
                        gnt_r       <= GNT_ONE << enc_sel_s;
                        gnt_idx_r   <= enc_sel_s;
                        gnt_valid_r <= 1'b1;
                    end else begin
                        preempt_r <= 1'b0;
                        if ((MAX_HOLD != 0) && (hold_cnt_r != HOLD_LAST)) begin
                            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    ptr_r       <= IDX_NONE;
                    hold_cnt_r  <= HOLD_ZERO;
                    gnt_r       <= GNT_NONE;
                    gnt_idx_r   <= IDX_NONE;
                    gnt_valid_r <= 1'b0;
                    preempt_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_idx   = gnt_idx_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.preempt   = preempt_r;

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one 8-way resource slot between 8 requesters.
- Produces a registered one-hot grant plus its 3-bit binary index, so the downstream datapath consumes the index directly.
- Grants are held while the owner keeps its request asserted, with a bounded hold time.
- Sits in front of any shared 8-way resource (bus, encoder channel, memory port) and replaces ad-hoc fixed-priority selection.

Parameters:
- N, 8, number of requesters (block is specified and verified for 8 only).
- IDX_W, 3, width of grant index (log2 N).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant while others wait; 0 disables the limit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request per requester; bit i high means requester i wants or keeps the slot.
- gnt  output  8  one-hot grant, registered; all-zero when no owner.
- gnt_idx  output  3  binary index of the set gnt bit; 0 when gnt_valid is 0.
- gnt_valid  output  1  high while any grant is active (equals OR of gnt).
- preempt  output  1  one-cycle pulse in the cycle a grant is transferred because of the MAX_HOLD limit.

Behaviour:
- Reset, asynchronous when rst_n is low:
  - gnt=0, gnt_idx=0, gnt_valid=0, preempt=0.
  - Round-robin pointer ptr=0, hold_cnt=0, state=IDLE.
  - Outputs drop immediately, including mid-grant; after release the first arbitration uses ptr=0.
- All outputs are registered; there is no combinational path from req to any output.
- States are IDLE and OWNED.
- IDLE:
  - req==0: stay in IDLE, outputs zero.
  - req!=0: select the first set bit searching from ptr upward, wrapping 7 to 0. Next cycle: gnt=onehot(sel), gnt_idx=sel, gnt_valid=1, hold_cnt=0, state=OWNED.
  - Latency from request to grant is 1 cycle.
- OWNED (owner o = gnt_idx):
  - Release: req[o]==0. Set ptr=(o+1) mod 8.
    - If any other req bit is set, hand off directly, with no idle bubble: next cycle the grant goes to the first set bit searching from the new ptr, and hold_cnt=0.
    - Otherwise: next cycle gnt=0, gnt_valid=0, gnt_idx=0, state=IDLE.
  - Hold: req[o]==1. hold_cnt increments, saturating at MAX_HOLD-1.
  - Preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[o]==1 and some other req bit is set.
    - Set ptr=(o+1) mod 8 and grant the next requester from ptr (never o itself) on the next cycle.
    - preempt=1 for exactly that cycle; hold_cnt=0.
  - Limit reached with no other requester: o keeps the grant, no preempt, and hold_cnt stays saturated.
- Search-order example: ptr=6 with req=8'b1000_0001 selects bit 6 if set, else 7, then 0.
- Simultaneous release and new requests: new request bits sampled in the release cycle take part in the handoff search.
- A grant never goes to a requester whose req bit is low in the sampling cycle.
- gnt is always zero or one-hot. gnt_idx always matches gnt.
- Fairness: while requester i is continuously requesting, it is granted within 7 owner tenures.

Decomposition:
- Shared package arb_pkg:
  - Constants ARB_N=8 and ARB_IDX_W=3.
  - State enum {IDLE, OWNED}.
  - Function for the one-hot to index conversion (8-to-3 encode).
- One natural sub-module: rr_prio_enc.
  - Combinational rotate-by-ptr, first-set-bit search and encode.
  - Inputs: req[7:0] and ptr[2:0]. Outputs: sel[2:0] and any_req.
  - Reused for both the IDLE search and the handoff search.

Test Plan:
- Reset then req=8'b0000_0100 → one cycle later gnt=8'b0000_0100, gnt_idx=3'd2, gnt_valid=1. Drop req → next cycle gnt=0, gnt_valid=0.
- Rotation: req=8'hFF held, and each owner drops its bit for one cycle after 2 cycles of ownership → grant order 0,1,2,...,7,0 with no idle cycles between owners.
- Handoff order with ptr=6:
  - After owner 5 releases with req=8'b1000_0001, the next grant is idx 7.
  - After 7 releases, the next grant is idx 0.
- Preempt, MAX_HOLD=16: req[3] held permanently, req[1] raised at cycle 2 of ownership → after 16 cycles owned by 3, preempt pulses for 1 cycle, gnt_idx=1, and gnt=8'b0000_0010.
- Saturation, MAX_HOLD=16: req[3] alone held for 40 cycles → gnt_idx stays 3 throughout and preempt is never asserted.
- Reset mid-grant: rst_n low while gnt_idx=5 → gnt, gnt_idx and gnt_valid are 0 immediately. After release with req=8'b0010_0001, the first grant is idx 0 because ptr was reset.
